// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl shared types: access sizes, FSM states, load side-band.
// Also holds the alignment legality helper.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] off;
    size_e      size;
    logic       uns;
    logic [4:0] rd;
  } ld_sb_t;

  function automatic logic acc_ok(
    input size_e      sz,
    input logic [1:0] lo
  );
    logic ok;
    unique case (sz)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~lo[0];
      SIZE_W:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl bundle: request handshake, RAM port,
// write-back response and error pulse.
interface lsu_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [4:0]    req_rd;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_cs;
  logic          ram_we;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_dout;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [4:0]    rsp_rd;

  logic          err_valid;
  logic [AW-1:0] err_addr;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr,
    input  req_wdata, req_rd,
    input  ram_dout, rsp_ready,
    output req_ready,
    output ram_addr, ram_din, ram_cs,
    output ram_we, ram_wem,
    output rsp_valid, rsp_rdata, rsp_rd,
    output err_valid, err_addr
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr,
    output req_wdata, req_rd,
    output ram_dout, rsp_ready,
    input  req_ready,
    input  ram_addr, ram_din, ram_cs,
    input  ram_we, ram_wem,
    input  rsp_valid, rsp_rdata, rsp_rd,
    input  err_valid, err_addr
  );

endinterface

// File: rtl/lsu_ctrl_load_align.sv
// Load data lane extraction and sign/zero
// extension for registered RAM read data.
module lsu_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = dout[{off, 3'b000} +: 8];
    h = dout[{off[1], 4'b0000} +: 16];
    unique case (size)
      SIZE_B:  rdata = {{24{~uns & b[7]}}, b};
      SIZE_H:  rdata = {{16{~uns & h[15]}}, h};
      default: rdata = dout;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store control in front of
// the data RAM, with a one-entry result skid.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  lsu_ctrl_if.slave  bus
);

  state_e        state_q;
  state_e        state_d;
  ld_sb_t        sb_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] fmt;
  logic          err_q;
  logic [AW-1:0] err_addr_q;
  logic [MW-1:0] wem;

  size_e      size;
  logic [1:0] lo;
  logic       legal;
  logic       fire;
  logic       issue;
  logic       ld_go;

  assign size  = size_e'(bus.req_size);
  assign lo    = bus.req_addr[1:0];
  assign legal = acc_ok(size, lo);
  assign fire  = bus.req_valid & bus.req_ready;
  assign issue = fire & legal;
  assign ld_go = issue & ~bus.req_we;

  lsu_load_align u_align (
    .dout  (bus.ram_dout),
    .off   (sb_q.off),
    .size  (sb_q.size),
    .uns   (sb_q.uns),
    .rdata (fmt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_go) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (!bus.rsp_ready) state_d = ST_HOLD;
        else if (ld_go)     state_d = ST_RD_WAIT;
        else                state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
      end
      ST_RD_WAIT: begin
        bus.req_ready = bus.rsp_ready;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = fmt;
      end
      ST_HOLD: begin
        bus.rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rd    = sb_q.rd;
  assign bus.err_valid = err_q;
  assign bus.err_addr  = err_addr_q;

  // Store data is lane-replicated; the mask picks the lanes.
  always_comb begin
    bus.ram_addr = bus.req_addr >> 2;
    bus.ram_cs   = issue;
    bus.ram_we   = issue & bus.req_we;
    bus.ram_din  = bus.req_wdata;
    wem          = '0;
    unique case (size)
      SIZE_B:  bus.ram_din = {4{bus.req_wdata[7:0]}};
      SIZE_H:  bus.ram_din = {2{bus.req_wdata[15:0]}};
      default: ;
    endcase
    if (bus.ram_we) begin
      unique case (size)
        SIZE_B:  wem = 4'b0001 << lo;
        SIZE_H:  wem = 4'b0011 << lo;
        default: wem = 4'b1111;
      endcase
    end
  end

  assign bus.ram_wem = wem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_q       <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (ld_go) begin
        sb_q.off  <= lo;
        sb_q.size <= size;
        sb_q.uns  <= bus.req_unsigned;
        sb_q.rd   <= bus.req_rd;
      end
      if (state_q == ST_RD_WAIT && !bus.rsp_ready)
        hold_q <= fmt;
      err_q <= fire & ~legal;
      if (fire & ~legal)
        err_addr_q <= bus.req_addr;
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage sitting directly upstream of the data RAM wrapper (`ram`) in the MEM stage.
- Accepts load/store requests from the EX/MEM pipeline register and drives the RAM's `addr`/`data_in`/`cs`/`we`/`wem` inputs.
- Captures the RAM's registered read data (`mem_data_o`, 1-cycle latency), then aligns and sign/zero-extends it.
- Delivers the load result to write-back with valid/ready backpressure, and flags misaligned or illegal accesses instead of touching the RAM.

Parameters:
- AW, 32, byte-address width of requests and width of ram_addr.
- DW, 32, data width; fixed at 32 for RV32.
- MW, 4, byte-lane write-mask width (DW/8).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU).
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- req_rd  in  5  destination register tag for loads.
- ram_addr  out  AW  word index = req_addr >> 2.
- ram_din  out  DW  lane-replicated store data.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_wem  out  MW  byte-lane write mask.
- ram_dout  in  DW  RAM read data, valid the cycle after a read issue.
- rsp_valid  out  1  load result valid.
- rsp_ready  in  1  write-back accepts result.
- rsp_rdata  out  DW  aligned, extended load data.
- rsp_rd  out  5  tag of returned load.
- err_valid  out  1  one-cycle pulse: misaligned/illegal access.
- err_addr  out  AW  faulting byte address.

Behaviour:
- Reset (async, rstn=0): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_rd=0, err_valid=0, err_addr=0. Any pending read is dropped; no response issues after reset release.
- FSM states:
  - IDLE: no outstanding read.
  - RD_WAIT: RAM data arrives this cycle.
  - HOLD: result held waiting for rsp_ready.
- req_ready = (state==IDLE) | (state==RD_WAIT & rsp_ready).
- Accept: fire = req_valid & req_ready.
- Legality:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: size=11.
  - A misaligned or illegal request is accepted but gives ram_cs=0, and err_valid=1 the next cycle with err_addr=req_addr. It produces no rsp and does not change state.
- RAM drive (combinational from request, only on a legal fire):
  - ram_cs=1, ram_we=req_we.
  - Otherwise ram_cs=0, ram_we=0, ram_wem=0.
- Store mask:
  - Byte: wem = 4'b0001 << addr[1:0], din = {4{wdata[7:0]}}.
  - Half: wem = 4'b0011 << addr[1:0], din = {2{wdata[15:0]}}.
  - Word: wem = 4'b1111, din = wdata.
  - Loads drive wem=0.
- Store timing: a store completes in its issue cycle; no response; state unchanged.
- Legal load:
  - Registers offset = addr[1:0], size, unsigned and rd into side-band registers.
  - State goes to RD_WAIT.
- RD_WAIT:
  - ram_dout is formatted: byte = dout[8*off +: 8], half = dout[16*off[1] +: 16], word = dout.
  - The result is sign- or zero-extended to 32 bits.
  - The result is presented combinationally: rsp_valid=1, rsp_rdata=formatted, rsp_rd=tag.
  - If rsp_ready=1: response retires. A simultaneous new legal load goes to RD_WAIT (back-to-back, one load per cycle); otherwise IDLE.
  - If rsp_ready=0: the formatted data is captured into a hold register, state goes to HOLD, and req_ready=0 the same cycle.
- HOLD:
  - rsp_valid=1 from the hold register; stays stable until rsp_ready.
  - On rsp_ready: state goes to IDLE; no request is accepted in that cycle.
- Simultaneous error and response: err_valid and rsp_valid may both be high; they are independent.

Decomposition:
- Shared package/defines: size encodings (SIZE_B/H/W), FSM state encodings, and reuse of the existing MemAddrBus/InstBus/MemUnit macros.
- One natural sub-module, `lsu_load_align`: a purely combinational extractor/extender taking (dout, off, size, unsigned) and returning rdata. The FSM, skid register and store masking stay in lsu_ctrl.

Test Plan:
- Reset mid-read: issue a load at 0x10, drop rstn in RD_WAIT -> all outputs 0, no rsp_valid after release.
- Store byte at addr 0x103, wdata 0xAB -> ram_cs=1, ram_we=1, ram_wem=4'b1000, ram_din=0xABABABAB, ram_addr=0x40; no rsp.
- Load half signed at 0x102, ram_dout 0x8001_1234 next cycle -> rsp_rdata=0xFFFF8001. Unsigned -> 0x00008001. rsp_rd echoes the tag.
- Back-to-back: loads at 0x0, 0x4 and 0x8 on consecutive cycles with rsp_ready=1 -> three consecutive rsp_valid cycles with matching words and tags.
- Backpressure: rsp_ready=0 for 3 cycles after a load -> state HOLD, rsp_rdata stable, req_ready=0. rsp_ready=1 -> retire, and req_ready=1 the next cycle.
- Misaligned word at 0x6 and size=11 at 0x8 -> ram_cs=0, err_valid pulses one cycle with err_addr=0x6 then 0x8, no rsp_valid.
